// File: rtl/console_mux_pkg.sv
// Shared types and defaults for the console mux UART drain path.
package console_mux_pkg;

    typedef enum logic [2:0] {
        IDLE,
        QUAL,
        START,
        DATA,
        STOP
    } tx_state_t;

    localparam int   DEF_CLKS_PER_BIT = 104;
    localparam int   DEF_DATA_BITS    = 8;
    localparam logic UART_IDLE        = 1'b1;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
module uart_baud_gen #(
    parameter  int CLKS_PER_BIT = 104,
    localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    output logic [CNT_W-1:0] count,
    output logic             tick
);

    assign tick = (count == CNT_W'(CLKS_PER_BIT - 1));

    always_ff @(posedge clk) begin
        if (rst || clear || tick) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops bytes from the mux output FIFO and serializes each as 8N1 on tx.
//  state | meaning
//  IDLE  | line idle, waiting for fifo_empty to drop
//  QUAL  | second non-empty cycle; head data now valid, latch and pop
//  START | start bit (tx=0), pop strobe on its first cycle
//  DATA  | data bits LSB first
//  STOP  | stop bit (tx=1), frame_done on its last cycle
module fifo_uart_tx
    import console_mux_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int DATA_BITS    = DEF_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] fifo_data,
    input  logic                 fifo_empty,
    output logic                 fifo_pop,
    output logic                 tx,
    output logic                 busy,
    output logic                 frame_done
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    tx_state_t            state, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [IDX_W-1:0]     bit_idx, bit_idx_d;
    logic                 pop_d, tx_d, busy_d, done_d;
    logic                 baud_clear, baud_tick;
    logic [CNT_W-1:0]     baud_cnt;

    // Holding the counter clear until START begins aligns bit boundaries to the start edge.
    assign baud_clear = (state == IDLE) || (state == QUAL);

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk  (clk),
        .rst  (rst),
        .clear(baud_clear),
        .count(baud_cnt),
        .tick (baud_tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            shift_q    <= '0;
            bit_idx    <= '0;
            fifo_pop   <= 1'b0;
            tx         <= UART_IDLE;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_d;
            shift_q    <= shift_d;
            bit_idx    <= bit_idx_d;
            fifo_pop   <= pop_d;
            tx         <= tx_d;
            busy       <= busy_d;
            frame_done <= done_d;
        end
    end

    always_comb begin
        state_d   = state;
        shift_d   = shift_q;
        bit_idx_d = bit_idx;
        pop_d     = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) state_d = QUAL;
            end
            QUAL: begin
                if (fifo_empty) begin
                    state_d = IDLE;
                end else begin
                    shift_d   = fifo_data;
                    bit_idx_d = '0;
                    pop_d     = 1'b1;
                    state_d   = START;
                end
            end
            START: begin
                if (baud_tick) state_d = DATA;
            end
            DATA: begin
                if (baud_tick) begin
                    shift_d = shift_q >> 1;
                    if (bit_idx == IDX_W'(DATA_BITS - 1)) begin
                        bit_idx_d = '0;
                        state_d   = STOP;
                    end else begin
                        bit_idx_d = bit_idx + 1'b1;
                    end
                end
            end
            STOP: begin
                if (baud_tick) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered, so they are derived from the state being entered.
        if (state_d == START) begin
            tx_d = 1'b0;
        end else if (state_d == DATA) begin
            tx_d = shift_d[0];
        end else begin
            tx_d = UART_IDLE;
        end
        busy_d = (state_d != IDLE);
        done_d = (state == STOP) && (baud_cnt == CNT_W'(CLKS_PER_BIT - 2));
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Randomized scoreboard bench for fifo_uart_tx with a behavioural FIFO and line model.
module tb_fifo_uart_tx;

    localparam int CPB   = 4;
    localparam int NB    = 8;
    localparam int FRAME = (NB + 2) * CPB;

    logic          clk;
    logic          rst;
    logic [NB-1:0] fifo_data;
    logic          fifo_empty;
    logic          fifo_pop;
    logic          tx;
    logic          busy;
    logic          frame_done;

    fifo_uart_tx #(
        .CLKS_PER_BIT(CPB),
        .DATA_BITS   (NB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .fifo_data (fifo_data),
        .fifo_empty(fifo_empty),
        .fifo_pop  (fifo_pop),
        .tx        (tx),
        .busy      (busy),
        .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stimulus-side controls
    logic          manual    = 1'b1;
    logic          man_empty = 1'b1;
    logic [NB-1:0] man_data  = '0;
    logic          push_en   = 1'b0;
    logic [NB-1:0] push_b    = '0;
    logic          exp_en    = 1'b0;
    logic [NB-1:0] exp_b     = '0;
    logic          done_req  = 1'b0;
    int            n_timeouts = 0;

    // FIFO model state
    logic [NB-1:0] fq[$];
    logic          mdl_empty = 1'b1;
    logic [NB-1:0] mdl_data  = '0;
    logic [NB-1:0] head_d    = '0;

    // Scoreboard of expected frames
    logic [NB-1:0] exp_mem [64];
    int            exp_wr = 0;
    int            exp_rd = 0;

    assign fifo_empty = manual ? man_empty : mdl_empty;
    assign fifo_data  = manual ? man_data  : mdl_data;

    // Registered-head FIFO: empty drops one cycle before the head data shows up.
    always @(posedge clk) begin
        if (fifo_pop && !manual && fq.size() > 0) fq.delete(0);
        if (push_en) fq.push_back(push_b);
        if (exp_en) begin
            exp_mem[exp_wr] = exp_b;
            exp_wr = exp_wr + 1;
        end
        mdl_empty <= (fq.size() == 0);
        mdl_data  <= head_d;
        head_d = (fq.size() != 0) ? fq[0] : NB'($urandom);
    end

    // Monitor
    int            total = 0;
    int            bad   = 0;
    int            cyc   = 0;
    logic          in_frame = 1'b0;
    int            k   = 0;
    int            gap = 0;
    logic          b2b = 1'b0;
    logic [NB-1:0] cur = '0;
    logic          prev_rst   = 1'b0;
    logic          prev_empty = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at t=%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Expected {tx, frame_done, busy, fifo_pop} at cycle kk of a frame carrying b.
    function automatic logic [3:0] exp_sample(input logic [NB-1:0] b, input int kk);
        int   bi;
        logic txv;
        bi = kk / CPB;
        if (bi == 0)       txv = 1'b0;
        else if (bi <= NB) txv = b[bi-1];
        else               txv = 1'b1;
        return {txv, (kk == FRAME - 1), 1'b1, (kk == 0)};
    endfunction

    always @(negedge clk) begin
        cyc++;
        if (cyc > 60000) begin
            total++;
            bad++;
            $display("FAIL watchdog: got %0d cycles expected below 60000", cyc);
            $display("test done: total=%0d bad=%0d", total, bad);
            $finish;
        end
        if (done_req) begin
            chk("frames_drained", exp_rd, exp_wr);
            chk("timeouts", n_timeouts, 0);
            $display("test done: total=%0d bad=%0d", total, bad);
            $finish;
        end
        if (rst) begin
            if (prev_rst) chk("reset_outputs", {tx, fifo_pop, busy, frame_done}, 4'b1000);
            in_frame = 1'b0;
            b2b = 1'b0;
        end else if (prev_rst) begin
            chk("post_reset_outputs", {tx, fifo_pop, busy, frame_done}, 4'b1000);
            gap = 0;
        end else begin
            if (!in_frame && tx === 1'b0) begin
                if (exp_rd == exp_wr) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_frame at t=%0t: got start bit expected idle line", $time);
                    cur = '0;
                end else begin
                    cur = exp_mem[exp_rd];
                    exp_rd = exp_rd + 1;
                end
                if (b2b) chk("b2b_gap", gap, 2);
                in_frame = 1'b1;
                k = 0;
            end
            if (in_frame) begin
                chk("frame_sample", {tx, frame_done, busy, fifo_pop}, exp_sample(cur, k));
                if (fifo_pop) chk("pop_while_empty", fifo_empty, 1'b0);
                k++;
                if (k == FRAME) begin
                    in_frame = 1'b0;
                    b2b = !fifo_empty;
                    gap = 0;
                end
            end else begin
                chk("idle_strobes", {frame_done, fifo_pop, busy & prev_empty}, 3'b000);
                gap++;
            end
        end
        prev_rst   = rst;
        prev_empty = fifo_empty;
    end

    // Stimulus
    task automatic send(input logic [NB-1:0] b);
        push_b  = b;
        exp_b   = b;
        push_en = 1'b1;
        exp_en  = 1'b1;
        @(posedge clk); #1;
        push_en = 1'b0;
        exp_en  = 1'b0;
    endtask

    task automatic add_exp(input logic [NB-1:0] b);
        exp_b  = b;
        exp_en = 1'b1;
        @(posedge clk); #1;
        exp_en = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int max);
        int n;
        n = 0;
        while (!(exp_rd == exp_wr && !in_frame && fq.size() == 0) && n < max) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= max) begin
            $display("FAIL %s: got still busy after %0d cycles expected drained", name, n);
            n_timeouts++;
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic wait_tx_low(input int max);
        int n;
        n = 0;
        while (tx !== 1'b0 && n < max) begin
            @(negedge clk);
            n++;
        end
        if (n >= max) begin
            $display("FAIL wait_start: got no start bit within %0d cycles expected one", n);
            n_timeouts++;
        end
    endtask

    task automatic wait_pop(input int max);
        int n;
        n = 0;
        while (fifo_pop !== 1'b1 && n < max) begin
            @(negedge clk);
            n++;
        end
        if (n >= max) begin
            $display("FAIL wait_pop: got no pop within %0d cycles expected one", n);
            n_timeouts++;
        end
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (4) @(posedge clk);
        #1 manual = 1'b0;

        send(8'h55);
        wait_drain("single_55", 300);

        send(8'hA5);
        send(8'h3C);
        wait_drain("b2b_a5_3c", 400);

        manual = 1'b1;
        man_empty = 1'b1;
        @(posedge clk); #1 man_empty = 1'b0;
        @(posedge clk); #1 man_empty = 1'b1;
        repeat (20) @(posedge clk);
        #1 manual = 1'b0;

        send(8'hFF);
        wait_tx_low(100);
        repeat (4 * CPB) @(negedge clk);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        send(8'h01);
        wait_drain("after_reset_01", 300);

        manual = 1'b1;
        man_data = 8'h81;
        man_empty = 1'b0;
        add_exp(8'h81);
        wait_pop(50);
        @(posedge clk); #1;
        man_empty = 1'b1;
        man_data = 8'h00;
        wait_drain("data_hold_81", 300);
        manual = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 16; i++) begin
            send(NB'($urandom));
            repeat ($urandom_range(0, 60)) @(posedge clk);
            #1;
        end
        wait_drain("random", 5000);

        done_req = 1'b1;
        repeat (5) @(posedge clk);
        $display("FAIL summary_missing: got no summary expected one");
        $fatal(1);
    end

endmodule
